// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer that drives the Fword/Pword inputs of the DDS datapath.
// Supports single-shot, continuous and triangle sweeps, with a programmable dwell per step.
module dds_sweep_ctrl #(
  parameter int DWELL_W = 16,
  parameter int FW_W    = 8,
  parameter int PW_W    = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [FW_W-1:0]    cfg_f_start,
  input  logic [FW_W-1:0]    cfg_f_stop,
  input  logic [FW_W-1:0]    cfg_f_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [PW_W-1:0]    cfg_phase,
  input  logic [1:0]         cfg_mode,
  output logic [FW_W-1:0]    Fword,
  output logic [PW_W-1:0]    Pword,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [FW_W-1:0]    fword_q, fword_d;
  logic [PW_W-1:0]    pword_q, pword_d;
  logic [FW_W-1:0]    f_start_q, f_start_d;
  logic [FW_W-1:0]    f_stop_q, f_stop_d;
  logic [FW_W-1:0]    step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               dir_q, dir_d;
  logic               start_dir_q, start_dir_d;
  logic               leg_q, leg_d;
  logic               wrap_q, wrap_d;

  logic [DWELL_W-1:0] dwell_last;
  logic [FW_W-1:0]    leg_end;
  logic               dwell_over;
  logic               at_end;
  logic               can_turn;
  logic [FW_W-1:0]    next_same;
  logic [FW_W-1:0]    next_turn;

  // One step from cur toward end in the given direction, clamped at end.
  // The extra top bit catches carry past full scale and borrow below zero.
  function automatic logic [FW_W-1:0] step_toward(
    input logic [FW_W-1:0] cur,
    input logic [FW_W-1:0] stp,
    input logic            up,
    input logic [FW_W-1:0] endp
  );
    logic [FW_W:0] sum;
    logic [FW_W:0] diff;
    sum  = {1'b0, cur} + {1'b0, stp};
    diff = {1'b0, cur} - {1'b0, stp};
    if (up) begin
      step_toward = (sum > {1'b0, endp}) ? endp : sum[FW_W-1:0];
    end else begin
      step_toward = (diff[FW_W] || (diff[FW_W-1:0] < endp)) ? endp : diff[FW_W-1:0];
    end
  endfunction

  always_comb begin
    dwell_last = (dwell_q == '0) ? '0 : dwell_q - 1'b1;
    dwell_over = (cnt_q == dwell_last);
    leg_end    = leg_q ? f_start_q : f_stop_q;
    at_end     = (fword_q == leg_end) || (step_q == '0);
    can_turn   = mode_q[1] && !leg_q && (f_start_q != f_stop_q) && (step_q != '0);
    next_same  = step_toward(fword_q, step_q, dir_q, leg_end);
    next_turn  = step_toward(fword_q, step_q, !dir_q, f_start_q);
  end

  always_comb begin
    state_d     = state_q;
    fword_d     = fword_q;
    pword_d     = pword_q;
    f_start_d   = f_start_q;
    f_stop_d    = f_stop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    start_dir_d = start_dir_q;
    leg_d       = leg_q;
    wrap_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_HOLD;
          f_start_d   = cfg_f_start;
          f_stop_d    = cfg_f_stop;
          step_d      = cfg_f_step;
          dwell_d     = cfg_dwell;
          mode_d      = cfg_mode;
          dir_d       = (cfg_f_start <= cfg_f_stop);
          start_dir_d = (cfg_f_start <= cfg_f_stop);
          leg_d       = 1'b0;
          cnt_d       = '0;
          fword_d     = cfg_f_start;
          pword_d     = cfg_phase;
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!dwell_over) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (!at_end) begin
            fword_d = next_same;
          end else if (can_turn) begin
            leg_d   = 1'b1;
            dir_d   = !dir_q;
            fword_d = next_turn;
          end else if (mode_q[0]) begin
            fword_d = f_start_q;
            dir_d   = start_dir_q;
            leg_d   = 1'b0;
            wrap_d  = 1'b1;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fword_q     <= '0;
      pword_q     <= '0;
      f_start_q   <= '0;
      f_stop_q    <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      dir_q       <= 1'b0;
      start_dir_q <= 1'b0;
      leg_q       <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fword_q     <= fword_d;
      pword_q     <= pword_d;
      f_start_q   <= f_start_d;
      f_stop_q    <= f_stop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      start_dir_q <= start_dir_d;
      leg_q       <= leg_d;
      wrap_q      <= wrap_d;
    end
  end

  assign Fword = fword_q;
  assign Pword = pword_q;
  assign busy  = (state_q == S_HOLD);
  assign done  = (state_q == S_FINISH);
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: drives on the falling edge, checks on the falling edge
// against hand-computed sweep sequences.
module tb_dds_sweep_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  cfg_f_start;
  logic [7:0]  cfg_f_stop;
  logic [7:0]  cfg_f_step;
  logic [15:0] cfg_dwell;
  logic [8:0]  cfg_phase;
  logic [1:0]  cfg_mode;
  logic [7:0]  Fword;
  logic [8:0]  Pword;
  logic        busy;
  logic        done;
  logic        wrap;

  int pass_cnt = 0;
  int total_cnt = 0;

  dds_sweep_ctrl #(.DWELL_W(16), .FW_W(8), .PW_W(9)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
    .cfg_dwell(cfg_dwell), .cfg_phase(cfg_phase), .cfg_mode(cfg_mode),
    .Fword(Fword), .Pword(Pword), .busy(busy), .done(done), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Issues a one-cycle start and returns at the first sample point after acceptance.
  task automatic start_sweep(input logic [7:0] fs, input logic [7:0] fe, input logic [7:0] st,
                             input logic [15:0] dw, input logic [8:0] ph, input logic [1:0] md);
    cfg_f_start = fs; cfg_f_stop = fe; cfg_f_step = st;
    cfg_dwell = dw; cfg_phase = ph; cfg_mode = md;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_f(input string tag, input logic [7:0] val, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check({tag, "_fword"}, Fword, val);
      check({tag, "_busy"}, busy, 1);
      @(negedge clk);
    end
  endtask

  task automatic expect_done(input string tag, input logic [7:0] last);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    @(negedge clk);
    check({tag, "_done_clr"}, done, 0);
    check({tag, "_fword_hold"}, Fword, last);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_f_start = '0; cfg_f_stop = '0; cfg_f_step = '0;
    cfg_dwell = '0; cfg_phase = '0; cfg_mode = '0;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("rst_fword", Fword, 0);
    check("rst_pword", Pword, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrap", wrap, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single sweep: 10,20,30,40 at three cycles each, done at T+13
    start_sweep(8'd10, 8'd40, 8'd10, 16'd3, 9'd5, 2'd0);
    check("single_pword", Pword, 5);
    expect_f("single_a", 8'd10, 3);
    expect_f("single_b", 8'd20, 3);
    expect_f("single_c", 8'd30, 3);
    expect_f("single_d", 8'd40, 3);
    expect_done("single", 8'd40);

    start_sweep(8'd10, 8'd35, 8'd10, 16'd1, 9'd7, 2'd0);
    expect_f("clamp_a", 8'd10, 1);
    expect_f("clamp_b", 8'd20, 1);
    expect_f("clamp_c", 8'd30, 1);
    expect_f("clamp_d", 8'd35, 1);
    expect_done("clamp", 8'd35);

    start_sweep(8'd200, 8'd255, 8'd100, 16'd1, 9'd0, 2'd0);
    expect_f("carry_a", 8'd200, 1);
    expect_f("carry_b", 8'd255, 1);
    expect_done("carry", 8'd255);

    start_sweep(8'd50, 8'd20, 8'd15, 16'd1, 9'd0, 2'd0);
    expect_f("down_a", 8'd50, 1);
    expect_f("down_b", 8'd35, 1);
    expect_f("down_c", 8'd20, 1);
    expect_done("down", 8'd20);

    for (int d = 0; d < 2; d++) begin
      start_sweep(8'd10, 8'd30, 8'd10, 16'(d), 9'd3, 2'd2);
      expect_f("tri_a", 8'd10, 1);
      expect_f("tri_b", 8'd20, 1);
      expect_f("tri_c", 8'd30, 1);
      expect_f("tri_d", 8'd20, 1);
      expect_f("tri_e", 8'd10, 1);
      expect_done("tri", 8'd10);
    end

    start_sweep(8'd77, 8'd77, 8'd5, 16'd2, 9'd1, 2'd2);
    expect_f("tri_single", 8'd77, 2);
    expect_done("tri_single", 8'd77);

    // Continuous with config scrambled right after start
    start_sweep(8'd0, 8'd2, 8'd1, 16'd2, 9'd9, 2'd1);
    cfg_f_start = 8'd99; cfg_f_stop = 8'd1; cfg_f_step = 8'd50;
    cfg_dwell = 16'd7; cfg_phase = 9'd300; cfg_mode = 2'd0;
    check("cont_wrap0", wrap, 0);
    expect_f("cont_a", 8'd0, 2);
    expect_f("cont_b", 8'd1, 2);
    expect_f("cont_c", 8'd2, 2);
    check("cont_wrap_f", Fword, 0);
    check("cont_wrap", wrap, 1);
    check("cont_nodone", done, 0);
    @(negedge clk);
    check("cont_wrap_clr", wrap, 0);
    check("cont_f0b", Fword, 0);
    check("cont_pword", Pword, 9);
    @(negedge clk);
    start = 1'b1;
    check("cont_f1a", Fword, 1);
    @(negedge clk);
    start = 1'b0;
    check("busy_start_f", Fword, 1);
    check("busy_start_b", busy, 1);
    check("busy_start_p", Pword, 9);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_fword", Fword, 1);
    check("abort_done", done, 0);
    check("abort_wrap", wrap, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_idle_done", done, 0);
      check("abort_idle_f", Fword, 1);
    end

    // Reset in the middle of a sweep, then restart
    start_sweep(8'd40, 8'd60, 8'd5, 16'd2, 9'd100, 2'd0);
    expect_f("pre_rst", 8'd40, 2);
    check("pre_rst_f2", Fword, 45);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_f", Fword, 0);
    check("mid_rst_p", Pword, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_wrap", wrap, 0);
    start_sweep(8'd3, 8'd3, 8'd0, 16'd1, 9'd511, 2'd0);
    check("post_rst_p", Pword, 511);
    expect_f("post_rst", 8'd3, 1);
    expect_done("post_rst", 8'd3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
